// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM read streamer: FSM encodings and skid buffer depth.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry valid/ready FIFO that absorbs BRAM read latency; occupancy feeds the credit logic.
module bram_rd_skid
  import bram_rd_pkg::*;
#(
  parameter int w = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [w-1:0] push_data_i,
  input  logic         pop_ready_i,
  output logic         pop_valid_o,
  output logic [w-1:0] pop_data_o,
  output logic [1:0]   occ_o
);

  logic [w-1:0] mem_q [SKID_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign pop_valid_o = (cnt_q != 2'd0);
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign occ_o       = cnt_q;
  assign pop         = pop_valid_o & pop_ready_i;

  always_comb begin
    cnt_d    = cnt_q + 2'(push_i) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never reset; an entry is only visible once the count covers it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bram_rd_streamer.sv
// BRAM read-side master: turns (addr, len) commands into a valid/ready word stream.
// Optional macro BRAM_RD_STALL_CNT_EN adds a saturating stall cycle counter output.
module bram_rd_streamer
  import bram_rd_pkg::*;
#(
  parameter int aw = 3,
  parameter int dw = 8,
  parameter int lw = aw + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [aw-1:0] cmd_addr_i,
  input  logic [lw-1:0] cmd_len_i,
  output logic [aw-1:0] raddr_o,
  input  logic [dw-1:0] rdout_i,
  output logic          dout_valid_o,
  input  logic          dout_ready_i,
  output logic [dw-1:0] dout_data_o,
  output logic          dout_last_o,
  output logic          busy_o,
  output logic          done_o
`ifdef BRAM_RD_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt_o
`endif
);

  state_e        state_q, state_d;
  logic [aw-1:0] cur_addr_q, cur_addr_d;
  logic [aw-1:0] raddr_q, raddr_d;
  logic [lw-1:0] len_q, len_d;
  logic [lw-1:0] issue_cnt_q, issue_cnt_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic          done_zero_q, done_zero_d;

  logic          accept, issue, issue_last, credit_ok, beat, last_beat;
  logic [2:0]    pending;
  logic [1:0]    occ;
  logic          skid_valid;
  logic [dw:0]   skid_word;

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign accept       = cmd_valid_i & cmd_ready_o;
  assign dout_valid_o = skid_valid;
  assign dout_data_o  = skid_word[dw-1:0];
  assign dout_last_o  = skid_valid & skid_word[dw];
  assign beat         = dout_valid_o & dout_ready_i;
  assign last_beat    = beat & dout_last_o;
  assign done_o       = done_zero_q | last_beat;

  // A word leaving this cycle frees its slot in time for a read issued now,
  // which is what allows one read per cycle with the consumer always ready.
  assign pending    = 3'(occ) + 3'(inflight_q) - 3'(beat);
  assign credit_ok  = pending < 3'(SKID_DEPTH);
  assign issue      = (state_q == ST_RUN) & credit_ok;
  assign issue_last = issue & (issue_cnt_q == len_q - lw'(1));
  assign raddr_o    = issue ? cur_addr_q : raddr_q;

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    len_d           = len_q;
    issue_cnt_d     = issue_cnt_q;
    raddr_d         = raddr_o;
    inflight_d      = issue;
    inflight_last_d = issue_last;
    done_zero_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cur_addr_d  = cmd_addr_i;
          len_d       = cmd_len_i;
          issue_cnt_d = '0;
          if (cmd_len_i == '0) done_zero_d = 1'b1;
          else                 state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          cur_addr_d  = cur_addr_q + aw'(1);
          issue_cnt_d = issue_cnt_q + lw'(1);
          if (issue_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      raddr_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_zero_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      raddr_q         <= raddr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_zero_q     <= done_zero_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_addr_q  <= cur_addr_d;
    len_q       <= len_d;
    issue_cnt_q <= issue_cnt_d;
  end

  // rdout_i is registered into the skid buffer, never forwarded to the stream.
  bram_rd_skid #(
    .w(dw + 1)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, rdout_i}),
    .pop_ready_i (dout_ready_i),
    .pop_valid_o (skid_valid),
    .pop_data_o  (skid_word),
    .occ_o       (occ)
  );

`ifdef BRAM_RD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept)                             stall_cnt_d = '0;
    else if (dout_valid_o & !dout_ready_i) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Self-checking bench for bram_rd_streamer: directed table, reset abort and random commands
// scored against a queue-based model of the expected word stream.
module tb_bram_rd_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [2:0] cmd_addr_i;
  logic [3:0] cmd_len_i;
  logic [2:0] raddr_o;
  logic [7:0] rdout_i;
  logic       dout_valid_o;
  logic       dout_ready_i;
  logic [7:0] dout_data_o;
  logic       dout_last_o;
  logic       busy_o;
  logic       done_o;
`ifdef BRAM_RD_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  logic [7:0] mem [8];
  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  // BRAM model: registered read address, data one cycle later.
  always @(posedge clk) rdout_i <= mem[raddr_o];

  bram_rd_streamer #(.aw(3), .dw(8), .lw(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_len_i    (cmd_len_i),
    .raddr_o      (raddr_o),
    .rdout_i      (rdout_i),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .dout_data_o  (dout_data_o),
    .dout_last_o  (dout_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef BRAM_RD_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one command to completion; the expected stream is the list of
  // words at addr, addr+1, ... modulo 8, with last on the len-th word.
  task automatic run_cmd(input logic [2:0] a, input logic [3:0] l, input int pct,
                         output int done_lat, output int first_lat,
                         output logic [7:0] first_d, output logic [7:0] last_d);
    logic [8:0] exp_q[$];
    logic [8:0] w;
    logic [8:0] prev_word;
    logic       prev_stall;
    int         c, nbeats, stalls;
    logic       got_done;
    for (int i = 0; i < int'(l); i++)
      exp_q.push_back({(i == int'(l) - 1), mem[(int'(a) + i) % 8]});
    done_lat = -1; first_lat = -1; first_d = '0; last_d = '0;
    prev_stall = 1'b0; prev_word = '0; c = 0; nbeats = 0; stalls = 0; got_done = 1'b0;

    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_len_i = l;
    dout_ready_i = (int'($urandom_range(99)) < pct);
    @(negedge clk);
    check("cmd_ready_at_accept", int'(cmd_ready_o), 1);

    while (!got_done && c < 300) begin
      @(posedge clk); #1;
      cmd_valid_i  = 1'b0;
      cmd_addr_i   = 3'($urandom_range(7));
      dout_ready_i = (int'($urandom_range(99)) < pct);
      @(negedge clk);
      c++;
      if (c == 1) begin
        if (l != 0) begin
          check("first_raddr", int'(raddr_o), int'(a));
          check("busy_running", int'(busy_o), 1);
        end else begin
          check("len0_cmd_ready", int'(cmd_ready_o), 1);
          check("len0_no_valid", int'(dout_valid_o), 0);
        end
      end
      if (prev_stall) begin
        check("valid_held", int'(dout_valid_o), 1);
        check("word_held", int'({dout_last_o, dout_data_o}), int'(prev_word));
      end
      if (dout_valid_o && first_lat < 0) first_lat = c;
      if (dout_valid_o && !dout_ready_i) stalls++;
      if (dout_valid_o && dout_ready_i) begin
        nbeats++;
        if (nbeats == 1) first_d = dout_data_o;
        last_d = dout_data_o;
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("beat_word", int'({dout_last_o, dout_data_o}), int'(w));
        end
      end
      if (done_o) begin
        got_done = 1'b1;
        done_lat = c;
        if (l != 0)
          check("done_with_last", int'(dout_valid_o & dout_ready_i & dout_last_o), 1);
`ifdef BRAM_RD_STALL_CNT_EN
        check("stall_cnt", int'(stall_cnt_o), stalls);
`endif
      end
      prev_stall = dout_valid_o && !dout_ready_i;
      prev_word  = {dout_last_o, dout_data_o};
    end
    check("done_seen", int'(got_done), 1);
    check("beat_count", nbeats, int'(l));

    @(posedge clk); #1;
    dout_ready_i = 1'b1;
    @(negedge clk);
    check("post_done_idle", int'({done_o, dout_valid_o, busy_o, cmd_ready_o}), 1);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [3:0] len;
    int         pct;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
    int         exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         dl, fl, beats;
    logic [7:0] fd, ld;

    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 'h10);
    vecs[0] = '{3'd2, 4'd4, 100, 8'h12, 8'h15, 6};
    vecs[1] = '{3'd6, 4'd4, 100, 8'h16, 8'h11, 6};
    vecs[2] = '{3'd0, 4'd8, 100, 8'h10, 8'h17, 10};
    vecs[3] = '{3'd3, 4'd8, 30,  8'h13, 8'h12, -1};
    vecs[4] = '{3'd5, 4'd1, 100, 8'h15, 8'h15, 3};
    vecs[5] = '{3'd7, 4'd2, 100, 8'h17, 8'h10, 4};
    vecs[6] = '{3'd0, 4'd0, 100, 8'h00, 8'h00, 1};

    rst = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; dout_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready_o), 1);
    check("rst_outputs", int'({dout_valid_o, dout_last_o, busy_o, done_o}), 0);
    check("rst_raddr", int'(raddr_o), 0);
`ifdef BRAM_RD_STALL_CNT_EN
    check("rst_stall_cnt", int'(stall_cnt_o), 0);
`endif

    foreach (vecs[i]) begin
      run_cmd(vecs[i].addr, vecs[i].len, vecs[i].pct, dl, fl, fd, ld);
      if (vecs[i].len != 0) begin
        check("vec_first_word", int'(fd), int'(vecs[i].exp_first));
        check("vec_last_word", int'(ld), int'(vecs[i].exp_last));
        check("vec_first_valid_lat", fl, 3);
      end
      if (vecs[i].exp_done >= 0) check("vec_done_lat", dl, vecs[i].exp_done);
    end

    // Abort a len=8 command after two beats.
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_addr_i = 3'd0; cmd_len_i = 4'd8; dout_ready_i = 1'b1;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      @(negedge clk);
      if (dout_valid_o && dout_ready_i) beats++;
    end
    check("abort_two_beats", beats, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", int'(dout_valid_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_cmd_ready", int'(cmd_ready_o), 1);
    check("abort_raddr", int'(raddr_o), 0);
    for (int c = 0; c < 4; c++) begin
      check("abort_no_done", int'({done_o, dout_valid_o}), 0);
      @(posedge clk);
      @(negedge clk);
    end
    run_cmd(3'd0, 4'd2, 100, dl, fl, fd, ld);
    check("after_abort_first", int'(fd), 'h10);
    check("after_abort_last", int'(ld), 'h11);

    for (int i = 0; i < 25; i++)
      run_cmd(3'($urandom_range(7)), 4'($urandom_range(8)),
              int'($urandom_range(20, 100)), dl, fl, fd, ld);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/bram_rd_streamer.md
Name: bram_rd_streamer

Overview:
- Read-side master for the simple dual-port BRAM wrapper, which has a registered read address and one-cycle read latency.
- Accepts a (start address, length) command and drives the BRAM read address.
- Absorbs the read latency and returns the words as a valid/ready stream with full backpressure.
- Sits between any BRAM buffer filled by a writer and downstream consumers such as PSL write-data paths or DMA egress.

Parameters:
- aw, 3, BRAM address width; depth is 2^aw.
- dw, 8, BRAM data width.
- lw, aw+1, command length width; lets a single command cover the full depth.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_addr_i  in  aw  start word address.
- cmd_len_i  in  lw  word count, 0..2^aw.
- raddr_o  out  aw  to BRAM raddr_i.
- rdout_i  in  dw  from BRAM rdout_o; valid the cycle after raddr_o is sampled.
- dout_valid_o  out  1  stream valid.
- dout_ready_i  in  1  stream ready.
- dout_data_o  out  dw  stream data.
- dout_last_o  out  1  marks the final beat of a command.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse when the command completes.

Behaviour:
- Reset values: cmd_ready_o=1, dout_valid_o=0, dout_last_o=0, busy_o=0, done_o=0, raddr_o=0, buffer empty, state IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: cmd_valid_i & cmd_ready_o -> latch addr and len.
    - len=0 -> stay IDLE, pulse done_o next cycle, emit no beats.
    - Otherwise -> RUN.
  - RUN: issue one read per cycle while issue_cnt < len and (buffer occupancy + reads in flight) < 2. Each issue drives raddr_o = cur_addr, then cur_addr++.
  - RUN -> DRAIN: on the cycle the last read is issued.
  - DRAIN -> IDLE: on the cycle the last beat handshakes (dout_valid_o & dout_ready_i & dout_last_o). done_o pulses in that same cycle.
- Read capture: a read issued in cycle N has rdout_i sampled into the 2-entry skid buffer at the end of cycle N+1. rdout_i is never used combinationally to drive dout_data_o.
- Latency:
  - Command handshake at edge T; first raddr_o is presented in cycle T+1.
  - dout_valid_o rises in cycle T+3.
  - With dout_ready_i held high, sustained throughput is 1 word/cycle.
- Address arithmetic: cur_addr is aw bits and wraps modulo 2^aw. Example: aw=3, addr=6, len=4 reads 6, 7, 0, 1.
- Stream rules:
  - dout_data_o and dout_last_o stay stable while dout_valid_o & !dout_ready_i.
  - dout_valid_o never drops without a handshake.
  - dout_last_o is asserted only together with the len-th beat.
- Backpressure: credits cap reads in flight plus buffered words at 2. No data is ever lost, and no read is issued without buffer space.
- raddr_o holds its last value when no read is issued. It is harmless because the BRAM read has no side effects.
- Coherence: the block gives no ordering guarantee for addresses that are written while a command covering them is in flight. The producer must complete its writes before issuing the command.
- Reset mid-operation: rst on any edge aborts the command.
  - Buffer and credits are flushed.
  - All outputs return to their reset values the next cycle.
  - done_o does not pulse.
- cmd_valid_i outside IDLE is ignored, since cmd_ready_o=0.

Optional Feature:
- Macro: BRAM_RD_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt_o, 16 bits.
  - Counts cycles with dout_valid_o & !dout_ready_i.
  - Saturates at 0xFFFF, clears on rst and on each command accept.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bram_rd_pkg holds:
  - FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2.
  - The constant SKID_DEPTH=2.
- One sub-module, bram_rd_skid: a 2-entry valid/ready skid FIFO carrying {last, data}, dw+1 bits wide, with an occupancy output used for credit accounting.

Test Plan:
- Basic burst: aw=3, BRAM preloaded mem[i]=i+0x10, cmd addr=2 len=4, dout_ready_i=1 -> beats 0x12, 0x13, 0x14, 0x15 on consecutive cycles; last on 0x15; first valid 3 cycles after handshake; done_o pulse with the last beat.
- Wrap: addr=6, len=4 -> data 0x16, 0x17, 0x10, 0x11.
- Full depth: addr=0, len=8 -> all 8 words, single last.
- Backpressure: random dout_ready_i at 30% duty, len=8 -> order and values exact, data stable under stall, no beat lost or duplicated. With the macro defined, stall_cnt_o equals the scoreboard stall count.
- len=0 -> no dout_valid_o; done_o pulses once the cycle after accept; cmd_ready_o stays 1.
- Reset mid-burst: assert rst after 2 beats of a len=8 command -> dout_valid_o=0 and busy_o=0 next cycle, no done_o. A new command addr=0 len=2 then returns 0x10, 0x11 correctly.
